// File: rtl/multiword_add_seq.sv
// ============================================================================
// Module      : multiword_add_seq
// Description : Streams Words slices of two wide operands through one external
//               Width-bit adder, chaining its carry to build a wide sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_add_seq #(
    parameter int Width = 8,
    parameter int Words = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [Width*Words-1:0]   A,
    input  logic [Width*Words-1:0]   B,
    input  logic                     CI,
    output logic [Width*Words-1:0]   S,
    output logic                     CO,
    output logic                     busy,
    output logic                     done,
    output logic [Width-1:0]         ADD_A,
    output logic [Width-1:0]         ADD_B,
    output logic                     ADD_CI,
    input  logic [Width-1:0]         ADD_S,
    input  logic                     ADD_CO
);

    localparam int c_idxW = (Words > 1) ? $clog2(Words) : 1;
    localparam logic [c_idxW-1:0] c_lastIdx = c_idxW'(Words - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [c_idxW-1:0]        r_index;
    logic                     r_carry;
    logic [Width*Words-1:0]   r_aReg;
    logic [Width*Words-1:0]   r_bReg;
    logic [Width*Words-1:0]   r_sum;
    logic                     r_co;
    logic                     w_lastSlice;

    assign w_lastSlice = (r_index == c_lastIdx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        ADD_A       = '0;
        ADD_B       = '0;
        ADD_CI      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                // Adder inputs come straight from registers so they are stable all cycle
                ADD_A  = r_aReg[r_index*Width +: Width];
                ADD_B  = r_bReg[r_index*Width +: Width];
                ADD_CI = r_carry;
                if (w_lastSlice) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= '0;
            r_carry <= 1'b0;
            r_aReg  <= '0;
            r_bReg  <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_aReg  <= A;
                        r_bReg  <= B;
                        r_carry <= CI;
                        r_index <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_index*Width +: Width] <= ADD_S;
                    r_carry                       <= ADD_CO;
                    if (w_lastSlice) begin
                        r_co    <= ADD_CO;
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + c_idxW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S  = r_sum;
    assign CO = r_co;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
// ============================================================================
// Module      : tb_multiword_add_seq
// Description : Directed bench for multiword_add_seq (Words=4 and Words=1)
//               with a behavioural Width-bit adder on the slice interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic        CI;
    logic [31:0] S;
    logic        CO, busy, done;
    logic [7:0]  addA, addB, addS;
    logic        addCi, addCo;

    logic        start1;
    logic [7:0]  A1, B1, S1;
    logic        CI1, CO1, busy1, done1;
    logic [7:0]  addA1, addB1, addS1;
    logic        addCi1, addCo1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {addCo, addS}   = {1'b0, addA} + {1'b0, addB} + {8'd0, addCi};
    assign {addCo1, addS1} = {1'b0, addA1} + {1'b0, addB1} + {8'd0, addCi1};

    multiword_add_seq #(.Width(8), .Words(4)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .CI(CI),
        .S(S), .CO(CO), .busy(busy), .done(done),
        .ADD_A(addA), .ADD_B(addB), .ADD_CI(addCi), .ADD_S(addS), .ADD_CO(addCo)
    );

    multiword_add_seq #(.Width(8), .Words(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(A1), .B(B1), .CI(CI1),
        .S(S1), .CO(CO1), .busy(busy1), .done(done1),
        .ADD_A(addA1), .ADD_B(addB1), .ADD_CI(addCi1), .ADD_S(addS1), .ADD_CO(addCo1)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation, then walks RUN and DONE checking handshake and result
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] expS, input logic expCo,
                         output logic [3:0] ciTrace);
        int busyCycles;
        A = a; B = b; CI = ci; start = 1'b1;
        tick();
        start = 1'b0; A = ~a; B = ~b; CI = ~ci;
        busyCycles = 0;
        ciTrace = '0;
        for (int i = 0; i < 4; i++) begin
            ciTrace[i] = addCi;
            if (busy) busyCycles++;
            if (done) checkVal({tag, "_early_done"}, 64'(done), 64'd0);
            tick();
        end
        checkVal({tag, "_done"}, 64'(done), 64'd1);
        checkVal({tag, "_S"}, 64'(S), 64'(expS));
        checkVal({tag, "_CO"}, 64'(CO), 64'(expCo));
        if (busy) busyCycles++;
        tick();
        checkVal({tag, "_done_width"}, 64'(done), 64'd0);
        checkVal({tag, "_busy_cycles"}, 64'(busyCycles), 64'd5);
    endtask

    logic [3:0]  ciTr;
    logic [31:0] holdS;
    logic        holdCo;
    int          doneSeen;

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0; CI = 1'b0;
        start1 = 1'b0; A1 = '0; B1 = '0; CI1 = 1'b0;
        tick();
        tick();
        checkVal("rst_S", 64'(S), 64'd0);
        checkVal("rst_CO_busy_done", {61'd0, CO, busy, done}, 64'd0);
        checkVal("rst_add", {47'd0, addA, addB, addCi}, 64'd0);
        checkVal("rst_w1", {52'd0, S1, CO1, busy1, done1, addCi1}, 64'd0);
        reset = 1'b0;
        tick();

        // Carry propagates through every slice
        runOp("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, ciTr);
        checkVal("ripple_ci_trace", 64'(ciTr), 64'b1110);

        runOp("nocarry", 32'h1234_5678, 32'h0101_0101, 1'b1, 32'h1335_577A, 1'b0, ciTr);
        checkVal("nocarry_ci_trace", 64'(ciTr), 64'b0001);

        // start held high while busy must not queue a second operation
        A = 32'h0000_00FF; B = 32'h0000_0001; CI = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            A = 32'h1111_1111 * (i + 2); B = 32'h0F0F_0F0F + i; CI = 1'b1;
            tick();
        end
        checkVal("busy_done", 64'(done), 64'd1);
        checkVal("busy_S1", 64'(S), 64'h100);
        checkVal("busy_CO1", 64'(CO), 64'd0);
        A = 32'hDEAD_BEEF; B = 32'h1234_4321;
        tick();
        checkVal("busy_idle_gap", {62'd0, busy, done}, 64'd0);
        A = 32'h0000_0010; B = 32'h0000_0020; CI = 1'b0;
        tick();
        start = 1'b0;
        checkVal("busy_second_accept", 64'(busy), 64'd1);
        A = 32'h5555_5555; B = 32'hAAAA_AAAA; CI = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkVal("busy_done2", 64'(done), 64'd1);
        checkVal("busy_S2", 64'(S), 64'h30);
        checkVal("busy_CO2", 64'(CO), 64'd0);
        tick();

        // Asynchronous reset in the second RUN cycle
        A = 32'h1111_1111; B = 32'h2222_2222; CI = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkVal("mid_pre_S", 64'(S), 64'h33);
        reset = 1'b1;
        #1;
        checkVal("mid_rst_flags", {62'd0, busy, done}, 64'd0);
        checkVal("mid_rst_S_CO", {31'd0, CO, S}, 64'd0);
        checkVal("mid_rst_add", {47'd0, addA, addB, addCi}, 64'd0);
        tick();
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) doneSeen++;
            tick();
        end
        checkVal("mid_no_done", 64'(doneSeen), 64'd0);
        runOp("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, ciTr);
        checkVal("post_rst_ci_trace", 64'(ciTr), 64'b1111);

        // Result holds while idle
        holdS = S; holdCo = CO;
        for (int i = 0; i < 10; i++) begin
            A = 32'h0F0F_0000 + i; B = 32'h1234_0000 + i;
            tick();
            checkVal("hold_S", 64'(S), 64'hFFFF_FFFF);
            checkVal("hold_rest", {46'd0, CO, busy, addA, addB, addCi},
                     {46'd0, holdCo, 1'b0, 17'd0});
        end
        checkVal("hold_S_same", 64'(S), 64'(holdS));

        // Single-slice instance
        A1 = 8'h80; B1 = 8'h80; CI1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; A1 = 8'h00; B1 = 8'h00; CI1 = 1'b0;
        checkVal("w1_run", {61'd0, busy1, done1, addCi1}, 64'b101);
        checkVal("w1_add_in", {48'd0, addA1, addB1}, 64'h8080);
        tick();
        checkVal("w1_done", 64'(done1), 64'd1);
        checkVal("w1_S_CO", {55'd0, CO1, S1}, 64'h101);
        tick();
        checkVal("w1_idle", {62'd0, busy1, done1}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
